// File: rtl/lzc_normalizer.sv
// rtl/lzc_normalizer.sv - two-stage leading-one detect and mantissa normaliser
module lzc_normalizer #(
  parameter  int WIDTH = 24,
  parameter  int EXP_W = 8,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mant_in,
  input  logic [EXP_W-1:0] exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mant_out,
  output logic [EXP_W-1:0] exp_out,
  output logic [SW-1:0]    shift_amt,
  output logic             zero,
  output logic             underflow
);

  // Common width for comparing the exponent against the shift count
  localparam int CW = (EXP_W > SW) ? EXP_W : SW;

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;

  logic [SW-1:0]    s1_pos;
  logic             s1_zero;
  logic [WIDTH-1:0] s1_mant;
  logic [EXP_W-1:0] s1_exp;

  logic [SW-1:0]    lead_pos;
  logic             in_zero;

  logic [SW-1:0]    nx_shift;
  logic [SW-1:0]    nx_amt;
  logic [WIDTH-1:0] nx_mant;
  logic [EXP_W-1:0] nx_exp;
  logic             nx_uf;

  // Handshake: each stage moves when its downstream slot is free or draining
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Leading-one position; later (higher) indices overwrite so the MSB wins
  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mant_in[i]) begin
        lead_pos = SW'(i);
      end
    end
    in_zero = (mant_in == '0);
  end

  // Shift/exponent adjustment; exponent clamps at zero and limits the shift
  always_comb begin
    nx_shift = SW'(WIDTH - 1) - s1_pos;
    nx_amt   = '0;
    nx_mant  = '0;
    nx_exp   = '0;
    nx_uf    = 1'b0;
    if (s1_zero) begin
      nx_amt  = '0;
      nx_mant = '0;
      nx_exp  = '0;
      nx_uf   = 1'b0;
    end else if (CW'(s1_exp) >= CW'(nx_shift)) begin
      nx_amt  = nx_shift;
      nx_mant = s1_mant << nx_shift;
      nx_exp  = s1_exp - EXP_W'(nx_shift);
      nx_uf   = 1'b0;
    end else begin
      nx_amt  = SW'(s1_exp);
      nx_mant = s1_mant << s1_exp;
      nx_exp  = '0;
      nx_uf   = 1'b1;
    end
  end

  // Stage 1: capture operand with its leading-one position
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pos   <= '0;
      s1_zero  <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_pos  <= lead_pos;
        s1_zero <= in_zero;
        s1_mant <= mant_in;
        s1_exp  <= exp_in;
      end
    end
  end

  // Stage 2: register normalised result; held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      mant_out  <= '0;
      exp_out   <= '0;
      shift_amt <= '0;
      zero      <= 1'b0;
      underflow <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        mant_out  <= nx_mant;
        exp_out   <= nx_exp;
        shift_amt <= nx_amt;
        zero      <= s1_zero;
        underflow <= nx_uf;
      end
    end
  end

endmodule

// File: tb/tb_lzc_normalizer.sv
// tb/tb_lzc_normalizer.sv - scoreboard bench for lzc_normalizer
module tb_lzc_normalizer;

  localparam int W  = 24;
  localparam int EW = 8;
  localparam int SW = 5;

  typedef struct {
    logic [W-1:0]  mant;
    logic [EW-1:0] ex;
    logic [SW-1:0] sh;
    logic          z;
    logic          u;
    bit            lat;
    int            acc;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  mant_in = '0;
  logic [EW-1:0] exp_in = '0;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  mant_out;
  logic [EW-1:0] exp_out;
  logic [SW-1:0] shift_amt;
  logic          zero;
  logic          underflow;

  bit   rand_rdy  = 1'b0;
  bit   rdy_force = 1'b1;
  bit   rdy_rand  = 1'b1;
  assign out_ready = rand_rdy ? rdy_rand : rdy_force;

  res_t sbq[$];
  int   pop_cyc[$];
  res_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   n0;

  lzc_normalizer #(.WIDTH(W), .EXP_W(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_in   (mant_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_out  (mant_out),
    .exp_out   (exp_out),
    .shift_amt (shift_amt),
    .zero      (zero),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rdy_rand = ($urandom_range(0, 9) < 7);
  end

  // Monitor: pop and compare on every output transfer
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      total++;
      pop_cyc.push_back(cyc);
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL stale_result got mant=%h exp=%0d want no output", mant_out, exp_out);
      end else begin
        mon_e = sbq.pop_front();
        if ({mant_out, exp_out, shift_amt, zero, underflow} !==
            {mon_e.mant, mon_e.ex, mon_e.sh, mon_e.z, mon_e.u}) begin
          bad++;
          $display("FAIL result got mant=%h exp=%0d sh=%0d z=%b u=%b want mant=%h exp=%0d sh=%0d z=%b u=%b",
                   mant_out, exp_out, shift_amt, zero, underflow,
                   mon_e.mant, mon_e.ex, mon_e.sh, mon_e.z, mon_e.u);
        end
        if (mon_e.lat) begin
          total++;
          if (cyc - mon_e.acc != 2) begin
            bad++;
            $display("FAIL latency got=%0d want=2", cyc - mon_e.acc);
          end
        end
      end
    end
  end

  function automatic res_t mk(logic [W-1:0] m, logic [EW-1:0] e, logic [SW-1:0] s,
                              logic z, logic u, bit lat);
    res_t r;
    r.mant = m; r.ex = e; r.sh = s; r.z = z; r.u = u; r.lat = lat; r.acc = 0;
    return r;
  endfunction

  // Reference: count leading zeros from the MSB, clamp by the exponent
  function automatic res_t model(logic [W-1:0] m, logic [EW-1:0] e);
    res_t r;
    int   lz;
    r = mk('0, '0, '0, 1'b0, 1'b0, 1'b0);
    if (m == '0) begin
      r.z = 1'b1;
    end else begin
      lz = 0;
      while (m[W-1-lz] == 1'b0) lz++;
      if (int'(e) >= lz) begin
        r.mant = m << lz;
        r.ex   = e - EW'(lz);
        r.sh   = SW'(lz);
      end else begin
        r.u    = 1'b1;
        r.mant = m << e;
        r.sh   = SW'(e);
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic send(input logic [W-1:0] m, input logic [EW-1:0] e, input res_t x);
    bit done = 1'b0;
    int n = 0;
    in_valid = 1'b1; mant_in = m; exp_in = e;
    while (!done && n < 60) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        x.acc = cyc;
        sbq.push_back(x);
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0; mant_in = W'($urandom); exp_in = EW'($urandom);
    if (!done) begin
      total++; bad++;
      $display("FAIL send_timeout got=not accepted want=accepted");
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0]  m;
    logic [EW-1:0] e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mant_out", mant_out, 0);
    chk("rst_exp_out", exp_out, 0);
    chk("rst_shift_amt", shift_amt, 0);
    chk("rst_zero", zero, 0);
    chk("rst_underflow", underflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed vectors, out_ready held high
    send(24'h000400, 8'd100, mk(24'h800000, 8'd87, 5'd13, 1'b0, 1'b0, 1'b1));
    send(24'h000001, 8'd10,  mk(24'h000400, 8'd0,  5'd10, 1'b0, 1'b1, 1'b1));
    send(24'h000001, 8'd23,  mk(24'h800000, 8'd0,  5'd23, 1'b0, 1'b0, 1'b1));
    send(24'h000000, 8'd55,  mk(24'h000000, 8'd0,  5'd0,  1'b1, 1'b0, 1'b1));
    send(24'h800001, 8'd5,   mk(24'h800001, 8'd5,  5'd0,  1'b0, 1'b0, 1'b1));
    send(24'h000003, 8'd0,   mk(24'h000003, 8'd0,  5'd0,  1'b0, 1'b1, 1'b1));
    send(24'h400000, 8'd1,   mk(24'h800000, 8'd0,  5'd1,  1'b0, 1'b0, 1'b1));
    send(24'h0F0F0F, 8'd3,   mk(24'h787878, 8'd0,  5'd3,  1'b0, 1'b1, 1'b1));
    send(24'h123456, 8'd200, mk(24'h91A2B0, 8'd197, 5'd3, 1'b0, 1'b0, 1'b1));
    wait_drain();

    // Backpressure: two accepted, third blocked, outputs held
    rdy_force = 1'b0;
    send(24'h000400, 8'd100, mk(24'h800000, 8'd87, 5'd13, 1'b0, 1'b0, 1'b0));
    send(24'h000001, 8'd10,  mk(24'h000400, 8'd0,  5'd10, 1'b0, 1'b1, 1'b0));
    in_valid = 1'b1; mant_in = 24'h000001; exp_in = 8'd23;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_hold_mant", mant_out, 32'h800000);
      chk("bp_hold_exp", exp_out, 87);
      chk("bp_hold_shift", shift_amt, 13);
    end
    @(posedge clk); #1;
    rdy_force = 1'b1;
    n0 = pop_cyc.size();
    send(24'h000001, 8'd23, mk(24'h800000, 8'd0, 5'd23, 1'b0, 1'b0, 1'b1));
    wait_drain();
    chk("bp_count", pop_cyc.size() - n0, 3);
    if (pop_cyc.size() >= n0 + 3) chk("bp_rate", pop_cyc[n0+2] - pop_cyc[n0], 2);

    // Reset mid-flight, with an input offered during reset
    rdy_force = 1'b0;
    send(24'h123456, 8'd200, mk(24'h91A2B0, 8'd197, 5'd3, 1'b0, 1'b0, 1'b0));
    send(24'h0F0F0F, 8'd3,   mk(24'h787878, 8'd0,   5'd3, 1'b0, 1'b1, 1'b0));
    in_valid = 1'b1; mant_in = 24'h000400; exp_in = 8'd100;
    rst = 1'b1;
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_mant_out", mant_out, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rdy_force = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(24'h400000, 8'd1, mk(24'h800000, 8'd0, 5'd1, 1'b0, 1'b0, 1'b1));
    wait_drain();

    // Random stream with random gaps and random out_ready
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; mant_in = W'($urandom); exp_in = EW'($urandom);
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      m = W'($urandom) >> $urandom_range(0, W);
      e = ($urandom_range(0, 1) == 1) ? EW'($urandom_range(0, 24)) : EW'($urandom_range(0, 255));
      send(m, e, model(m, e));
    end
    rand_rdy = 1'b0;
    rdy_force = 1'b1;
    wait_drain();
    chk("final_queue_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
